// File: rtl/wb_mult_pkg.sv
// Shared register map, bit positions and helpers for the Wishbone multiplier array.
package wb_mult_pkg;

   localparam logic [6:0] ADDR_ID      = 7'h00;
   localparam logic [6:0] ADDR_REV     = 7'h01;
   localparam logic [6:0] ADDR_CTRL    = 7'h02;
   localparam logic [6:0] ADDR_MODE    = 7'h03;
   localparam logic [6:0] ADDR_CH_BASE = 7'h04;

   localparam logic [31:0] ID_VALUE          = 32'h0000_4D55;
   localparam logic [31:0] DEF_REG_VALUE_DEF = 32'hFAB_DEF_AC;

   localparam int CTRL_START_LSB = 0;
   localparam int CTRL_DONE_LSB  = 0;
   localparam int CTRL_BUSY_LSB  = 8;
   localparam int CTRL_OVR_LSB   = 12;
   localparam int CTRL_CLR_LSB   = 16;
   localparam int CTRL_IRQ_LSB   = 24;
   localparam int MODE_SGN_LSB   = 0;
   localparam int MODE_ACC_LSB   = 8;

   typedef enum logic [1:0] {
      CH_A_IN    = 2'd0,
      CH_B_IN    = 2'd1,
      CH_C_OUT_L = 2'd2,
      CH_C_OUT_H = 2'd3
   } ch_reg_e;

   function automatic logic [6:0] ch_addr(input int ch, input ch_reg_e r);
      return ADDR_CH_BASE + 7'(4 * ch) + 7'(r);
   endfunction

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] wr_val,
                                              input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = wr_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/wb_mult_lane.sv
// One multiplier channel: product capture on START, fixed-latency pipeline,
// optional 64-bit accumulate and DONE/BUSY/OVERRUN status.
module wb_mult_lane #(
   parameter int DATA_W      = 32,
   parameter int PIPE_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              clr_done,
   input  logic              signed_mode,
   input  logic              accum,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic              busy,
   output logic              overrun,
   output logic [63:0]       c_out
);

   logic [63:0]            a_ext, b_ext, prod;
   logic [63:0]            prod_q [PIPE_STAGES];
   logic [PIPE_STAGES-1:0] acc_q, vld_q;
   logic                   accept, complete;

   // A 64x64 product truncated to 64 bits equals the 2*DATA_W product extended per mode.
   assign a_ext    = {{(64-DATA_W){a[DATA_W-1] & signed_mode}}, a};
   assign b_ext    = {{(64-DATA_W){b[DATA_W-1] & signed_mode}}, b};
   assign prod     = a_ext * b_ext;
   assign accept   = start & ~busy;
   assign complete = vld_q[PIPE_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PIPE_STAGES; i++) prod_q[i] <= '0;
         acc_q   <= '0;
         vld_q   <= '0;
         c_out   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         vld_q[0] <= accept;
         if (accept) begin
            prod_q[0] <= prod;
            acc_q[0]  <= accum;
         end
         for (int i = 1; i < PIPE_STAGES; i++) begin
            vld_q[i]  <= vld_q[i-1];
            prod_q[i] <= prod_q[i-1];
            acc_q[i]  <= acc_q[i-1];
         end

         if (complete) begin
            c_out <= acc_q[PIPE_STAGES-1] ? c_out + prod_q[PIPE_STAGES-1]
                                          : prod_q[PIPE_STAGES-1];
         end

         if (accept)        busy <= 1'b1;
         else if (complete) busy <= 1'b0;

         // Completion beats a same-cycle DONE clear.
         if (complete)                 done <= 1'b1;
         else if (accept || clr_done)  done <= 1'b0;

         if (start && busy) overrun <= 1'b1;
         else if (accept)   overrun <= 1'b0;
      end
   end

endmodule

// File: rtl/wb_mult_array.sv
// Wishbone slave wrapping NUM_CH independent multiplier lanes; register decode
// and byte-enable handling live here, arithmetic lives in wb_mult_lane.
module wb_mult_array import wb_mult_pkg::*; #(
   parameter int          NUM_CH        = 2,
   parameter int          DATA_W        = 32,
   parameter int          PIPE_STAGES   = 2,
   parameter logic [31:0] DEF_REG_VALUE = DEF_REG_VALUE_DEF
) (
   input  logic        WB_CLK,
   input  logic        WB_RST_N,
   input  logic [6:0]  WBs_ADR,
   input  logic        WBs_CYC,
   input  logic        WBs_STB,
   input  logic        WBs_WE,
   input  logic [3:0]  WBs_BYTE_STB,
   input  logic [31:0] WBs_WR_DAT,
   output logic [31:0] WBs_RD_DAT,
   output logic        WBs_ACK,
   output logic        Mult_Irq
);

   logic              wb_req, wb_wr, ctrl_wr;
   logic [NUM_CH-1:0] start_v, clr_v, done_v, busy_v, ovr_v;
   logic [NUM_CH-1:0] irq_en, mode_sgn, mode_acc;
   logic [DATA_W-1:0] a_in [NUM_CH];
   logic [DATA_W-1:0] b_in [NUM_CH];
   logic [63:0]       c_out [NUM_CH];
   logic [31:0]       rd_next, rev_val;

   assign wb_req  = WBs_CYC & WBs_STB & ~WBs_ACK;
   assign wb_wr   = wb_req & WBs_WE;
   assign ctrl_wr = wb_wr && (WBs_ADR == ADDR_CTRL);
   assign start_v = (ctrl_wr && WBs_BYTE_STB[0]) ? WBs_WR_DAT[CTRL_START_LSB +: NUM_CH] : '0;
   assign clr_v   = (ctrl_wr && WBs_BYTE_STB[2]) ? WBs_WR_DAT[CTRL_CLR_LSB +: NUM_CH]   : '0;
   assign rev_val = {13'd0, 3'(PIPE_STAGES), 2'd0, 6'(DATA_W), 4'd0, 4'(NUM_CH)};
   assign Mult_Irq = |(done_v & irq_en);

   always_comb begin
      rd_next = DEF_REG_VALUE;
      case (WBs_ADR)
         ADDR_ID:   rd_next = ID_VALUE;
         ADDR_REV:  rd_next = rev_val;
         ADDR_CTRL: begin
            rd_next = '0;
            rd_next[CTRL_DONE_LSB +: NUM_CH] = done_v;
            rd_next[CTRL_BUSY_LSB +: NUM_CH] = busy_v;
            rd_next[CTRL_OVR_LSB  +: NUM_CH] = ovr_v;
            rd_next[CTRL_IRQ_LSB  +: NUM_CH] = irq_en;
         end
         ADDR_MODE: begin
            rd_next = '0;
            rd_next[MODE_SGN_LSB +: NUM_CH] = mode_sgn;
            rd_next[MODE_ACC_LSB +: NUM_CH] = mode_acc;
         end
         default: ;
      endcase
      for (int c = 0; c < NUM_CH; c++) begin
         if (WBs_ADR == ch_addr(c, CH_A_IN))    rd_next = 32'(a_in[c]);
         if (WBs_ADR == ch_addr(c, CH_B_IN))    rd_next = 32'(b_in[c]);
         if (WBs_ADR == ch_addr(c, CH_C_OUT_L)) rd_next = c_out[c][31:0];
         if (WBs_ADR == ch_addr(c, CH_C_OUT_H)) rd_next = c_out[c][63:32];
      end
   end

   always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
      if (!WB_RST_N) begin
         WBs_ACK    <= 1'b0;
         WBs_RD_DAT <= '0;
         irq_en     <= '0;
         mode_sgn   <= '0;
         mode_acc   <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            a_in[c] <= '0;
            b_in[c] <= '0;
         end
      end else begin
         WBs_ACK    <= wb_req;
         WBs_RD_DAT <= wb_req ? rd_next : '0;
         if (ctrl_wr && WBs_BYTE_STB[3]) irq_en <= WBs_WR_DAT[CTRL_IRQ_LSB +: NUM_CH];
         if (wb_wr && (WBs_ADR == ADDR_MODE)) begin
            if (WBs_BYTE_STB[0]) mode_sgn <= WBs_WR_DAT[MODE_SGN_LSB +: NUM_CH];
            if (WBs_BYTE_STB[1]) mode_acc <= WBs_WR_DAT[MODE_ACC_LSB +: NUM_CH];
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (wb_wr && (WBs_ADR == ch_addr(c, CH_A_IN)))
               a_in[c] <= DATA_W'(byte_merge(32'(a_in[c]), WBs_WR_DAT, WBs_BYTE_STB));
            if (wb_wr && (WBs_ADR == ch_addr(c, CH_B_IN)))
               b_in[c] <= DATA_W'(byte_merge(32'(b_in[c]), WBs_WR_DAT, WBs_BYTE_STB));
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      wb_mult_lane #(
         .DATA_W      (DATA_W),
         .PIPE_STAGES (PIPE_STAGES)
      ) u_lane (
         .clk         (WB_CLK),
         .rst_n       (WB_RST_N),
         .start       (start_v[g]),
         .clr_done    (clr_v[g]),
         .signed_mode (mode_sgn[g]),
         .accum       (mode_acc[g]),
         .a           (a_in[g]),
         .b           (b_in[g]),
         .done        (done_v[g]),
         .busy        (busy_v[g]),
         .overrun     (ovr_v[g]),
         .c_out       (c_out[g])
      );
   end

endmodule

// File: tb/tb_wb_mult_array.sv
// Bench for wb_mult_array: register vector table, directed multi-cycle sequences
// and randomized multiply/accumulate runs against an arithmetic reference.
module tb_wb_mult_array;

   logic        WB_CLK = 1'b0;
   logic        WB_RST_N;
   logic [6:0]  WBs_ADR;
   logic        WBs_CYC, WBs_STB, WBs_WE;
   logic [3:0]  WBs_BYTE_STB;
   logic [31:0] WBs_WR_DAT;
   logic [31:0] WBs_RD_DAT;
   logic        WBs_ACK;
   logic        Mult_Irq;

   int checks   = 0;
   int failures = 0;

   always #5 WB_CLK = ~WB_CLK;

   wb_mult_array #(
      .NUM_CH        (2),
      .DATA_W        (32),
      .PIPE_STAGES   (2),
      .DEF_REG_VALUE (32'hFABDEFAC)
   ) dut (
      .WB_CLK       (WB_CLK),
      .WB_RST_N     (WB_RST_N),
      .WBs_ADR      (WBs_ADR),
      .WBs_CYC      (WBs_CYC),
      .WBs_STB      (WBs_STB),
      .WBs_WE       (WBs_WE),
      .WBs_BYTE_STB (WBs_BYTE_STB),
      .WBs_WR_DAT   (WBs_WR_DAT),
      .WBs_RD_DAT   (WBs_RD_DAT),
      .WBs_ACK      (WBs_ACK),
      .Mult_Irq     (Mult_Irq)
   );

   typedef struct {
      string       name;
      bit          wr;
      logic [6:0]  adr;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;

   vec_t        vecs[$];
   logic [63:0] model_c [2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic wb_xfer(input logic [6:0] adr, input logic we, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rd);
      int n;
      WBs_ADR = adr; WBs_WE = we; WBs_WR_DAT = wd; WBs_BYTE_STB = be;
      WBs_CYC = 1'b1; WBs_STB = 1'b1;
      n = 0;
      do begin
         @(posedge WB_CLK); #1;
         n++;
      end while (!WBs_ACK && n < 8);
      if (!WBs_ACK) begin
         checks++; failures++;
         $display("FAIL ack_timeout adr=%h actual=0 expected=1", adr);
      end
      rd = WBs_RD_DAT;
      WBs_CYC = 1'b0; WBs_STB = 1'b0; WBs_WE = 1'b0;
   endtask

   task automatic wb_write(input logic [6:0] adr, input logic [31:0] wd, input logic [3:0] be);
      logic [31:0] dummy;
      wb_xfer(adr, 1'b1, wd, be, dummy);
   endtask

   task automatic wb_read(input logic [6:0] adr, output logic [31:0] rd);
      wb_xfer(adr, 1'b0, 32'd0, 4'd0, rd);
   endtask

   task automatic read_check(input string name, input logic [6:0] adr, input logic [31:0] exp);
      logic [31:0] r;
      wb_read(adr, r);
      check(name, 64'(r), 64'(exp));
   endtask

   task automatic wait_done(input int ch);
      logic [31:0] r;
      bit seen;
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         wb_read(7'h02, r);
         if (r[ch]) seen = 1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL done_timeout ch=%0d actual=0 expected=1", ch);
      end
   endtask

   task automatic do_reset();
      WB_RST_N = 1'b0;
      repeat (2) @(posedge WB_CLK);
      #1 WB_RST_N = 1'b1;
   endtask

   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input bit sgn);
      longint sa, sb;
      if (sgn) begin
         sa = longint'(signed'(a));
         sb = longint'(signed'(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      return 64'(sa * sb);
   endfunction

   initial begin
      logic [31:0] r, a, b, mode_w;
      logic [3:0]  ack_pat;
      logic [63:0] exp64;
      int          ch;
      bit          sg, ac;

      WB_RST_N = 1'b0; WBs_ADR = '0; WBs_CYC = 0; WBs_STB = 0; WBs_WE = 0;
      WBs_BYTE_STB = '0; WBs_WR_DAT = '0;
      repeat (3) @(posedge WB_CLK);
      #1;
      check("rst_ack", 64'(WBs_ACK), 64'd0);
      check("rst_rd",  64'(WBs_RD_DAT), 64'd0);
      check("rst_irq", 64'(Mult_Irq), 64'd0);
      WB_RST_N = 1'b1;
      @(posedge WB_CLK); #1;
      read_check("rst_ctrl", 7'h02, 32'h0);
      read_check("rst_mode", 7'h03, 32'h0);

      vecs.push_back('{"id",          0, 7'h00, 32'h0,          4'h0, 32'h0000_4D55});
      vecs.push_back('{"rev",         0, 7'h01, 32'h0,          4'h0, 32'h0002_2002});
      vecs.push_back('{"a0_be0101",   1, 7'h04, 32'hAABB_CCDD,  4'h5, 32'h00BB_00DD});
      vecs.push_back('{"a0_be1010",   1, 7'h04, 32'h1122_3344,  4'hA, 32'h11BB_33DD});
      vecs.push_back('{"b1_full",     1, 7'h09, 32'h1234_5678,  4'hF, 32'h1234_5678});
      vecs.push_back('{"unmapped_7f", 0, 7'h7F, 32'h0,          4'h0, 32'hFABD_EFAC});
      vecs.push_back('{"ch2_a_ign",   1, 7'h0C, 32'h0000_0055,  4'hF, 32'hFABD_EFAC});
      vecs.push_back('{"mode_all",    1, 7'h03, 32'hFFFF_FFFF,  4'hF, 32'h0000_0303});
      vecs.push_back('{"mode_b0",     1, 7'h03, 32'h0000_0000,  4'h1, 32'h0000_0300});
      vecs.push_back('{"mode_b1",     1, 7'h03, 32'h0000_0000,  4'h2, 32'h0000_0000});
      vecs.push_back('{"ctrl_irq",    1, 7'h02, 32'hFF00_00FF,  4'h8, 32'h0300_0000});
      vecs.push_back('{"ctrl_irq0",   1, 7'h02, 32'h0000_0000,  4'h8, 32'h0000_0000});
      vecs.push_back('{"id_ro",       1, 7'h00, 32'h1234_5678,  4'hF, 32'h0000_4D55});
      vecs.push_back('{"cout_ro",     1, 7'h06, 32'h1234_5678,  4'hF, 32'h0000_0000});
      foreach (vecs[i]) begin
         if (vecs[i].wr) wb_write(vecs[i].adr, vecs[i].wd, vecs[i].be);
         read_check(vecs[i].name, vecs[i].adr, vecs[i].exp);
      end

      // Unsigned max operands with exact completion latency seen on Mult_Irq
      wb_write(7'h03, 32'h0, 4'hF);
      wb_write(7'h04, 32'hFFFF_FFFF, 4'hF);
      wb_write(7'h05, 32'hFFFF_FFFF, 4'hF);
      wb_write(7'h02, 32'h0100_0000, 4'h8);
      wb_write(7'h02, 32'h0000_0001, 4'h1);
      @(posedge WB_CLK); #1;
      check("irq_lat1", 64'(Mult_Irq), 64'd0);
      @(posedge WB_CLK); #1;
      check("irq_lat2", 64'(Mult_Irq), 64'd1);
      read_check("umax_l", 7'h06, 32'h0000_0001);
      read_check("umax_h", 7'h07, 32'hFFFF_FFFE);
      read_check("umax_ctrl", 7'h02, 32'h0100_0001);
      wb_write(7'h02, 32'h0001_0000, 4'h4);
      read_check("clr_done", 7'h02, 32'h0100_0000);
      check("irq_clr", 64'(Mult_Irq), 64'd0);

      // Signed
      wb_write(7'h03, 32'h1, 4'hF);
      wb_write(7'h04, 32'hFFFF_FFFE, 4'hF);
      wb_write(7'h05, 32'h0000_0003, 4'hF);
      wb_write(7'h02, 32'h1, 4'h1);
      wait_done(0);
      read_check("sgn_l", 7'h06, 32'hFFFF_FFFA);
      read_check("sgn_h", 7'h07, 32'hFFFF_FFFF);

      // Accumulate on ch1
      wb_write(7'h03, 32'h200, 4'hF);
      wb_write(7'h08, 32'd5, 4'hF);
      wb_write(7'h09, 32'd7, 4'hF);
      wb_write(7'h02, 32'h2, 4'h1);
      wait_done(1);
      wb_write(7'h02, 32'h2, 4'h1);
      wait_done(1);
      read_check("acc_l", 7'h0A, 32'd70);
      read_check("acc_h", 7'h0B, 32'd0);

      // Overrun, then operand writes during BUSY
      wb_write(7'h03, 32'h0, 4'hF);
      wb_write(7'h04, 32'd3, 4'hF);
      wb_write(7'h05, 32'd4, 4'hF);
      wb_write(7'h02, 32'h1, 4'h1);
      wb_write(7'h02, 32'h1, 4'h1);
      wait_done(0);
      read_check("ovr_ctrl", 7'h02, 32'h0100_1003);
      read_check("ovr_l", 7'h06, 32'd12);
      wb_write(7'h02, 32'h1, 4'h1);
      wb_write(7'h04, 32'd100, 4'hF);
      wait_done(0);
      read_check("busy_wr_l", 7'h06, 32'd12);
      read_check("ovr_cleared", 7'h02, 32'h0100_0003);
      wb_write(7'h02, 32'h1, 4'h1);
      wait_done(0);
      read_check("new_a_l", 7'h06, 32'd400);

      // DONE clear lands on the completion edge
      wb_write(7'h02, 32'h1, 4'h1);
      wb_write(7'h02, 32'h0001_0000, 4'h4);
      read_check("done_wins", 7'h02, 32'h0100_0003);
      wb_write(7'h02, 32'h0001_0000, 4'h4);
      read_check("done_clr", 7'h02, 32'h0100_0002);

      // Simultaneous start on both channels
      wb_write(7'h02, 32'h0003_0000, 4'h4);
      wb_write(7'h04, 32'd6, 4'hF);
      wb_write(7'h05, 32'd7, 4'hF);
      wb_write(7'h08, 32'd10, 4'hF);
      wb_write(7'h09, 32'd20, 4'hF);
      wb_write(7'h02, 32'h3, 4'h1);
      wait_done(0);
      wait_done(1);
      read_check("dual_l0", 7'h06, 32'd42);
      read_check("dual_l1", 7'h0A, 32'd200);

      // Held request: ACK alternates, never back-to-back
      @(posedge WB_CLK); #1;
      WBs_ADR = 7'h00; WBs_WE = 0; WBs_CYC = 1; WBs_STB = 1;
      ack_pat = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         @(posedge WB_CLK); #1;
         check($sformatf("ack_pat%0d", k), 64'(WBs_ACK), 64'(ack_pat[k]));
      end
      WBs_CYC = 0; WBs_STB = 0;

      // Randomized against arithmetic reference
      do_reset();
      model_c[0] = '0;
      model_c[1] = '0;
      for (int i = 0; i < 40; i++) begin
         ch = $urandom_range(0, 1);
         a  = (i % 8 == 0) ? 32'h8000_0000 : $urandom;
         b  = (i % 8 == 1) ? 32'hFFFF_FFFF : $urandom;
         sg = 1'($urandom_range(0, 1));
         ac = 1'($urandom_range(0, 1));
         mode_w = '0;
         mode_w[ch] = sg;
         mode_w[8 + ch] = ac;
         wb_write(7'h03, mode_w, 4'hF);
         wb_write(7'(4 + 4 * ch), a, 4'hF);
         wb_write(7'(5 + 4 * ch), b, 4'hF);
         wb_write(7'h02, 32'(1 << ch), 4'h1);
         exp64 = ref_prod(a, b, sg) + (ac ? model_c[ch] : 64'd0);
         model_c[ch] = exp64;
         wait_done(ch);
         read_check($sformatf("rnd%0d_l", i), 7'(6 + 4 * ch), exp64[31:0]);
         read_check($sformatf("rnd%0d_h", i), 7'(7 + 4 * ch), exp64[63:32]);
         wb_write(7'h02, 32'(1 << (16 + ch)), 4'h4);
      end

      // Reset while ch0 is in flight
      wb_write(7'h03, 32'h0, 4'hF);
      wb_write(7'h02, 32'h0100_0000, 4'h8);
      wb_write(7'h04, 32'd9, 4'hF);
      wb_write(7'h05, 32'd9, 4'hF);
      wb_write(7'h02, 32'h1, 4'h1);
      WB_RST_N = 1'b0;
      @(posedge WB_CLK); #1;
      WB_RST_N = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge WB_CLK); #1;
         check($sformatf("rst_mid_irq%0d", k), 64'(Mult_Irq), 64'd0);
      end
      read_check("rst_mid_ctrl", 7'h02, 32'h0);
      read_check("rst_mid_l", 7'h06, 32'h0);
      read_check("rst_mid_h", 7'h07, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
